// File: rtl/pwm_from_count.sv
// PWM generator driven by an upstream up_counter's count bus, with double-buffered duty,
// wrap pulse, sticky irq and period counter. Define PWM_POL_INV_EN for an active-low pwm_out.
module pwm_from_count #(
   parameter int WIDTH  = 8,
   parameter int PCNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  count,
   input  logic              duty_wr,
   input  logic [WIDTH-1:0]  duty_in,
   input  logic              irq_clr,
   output logic              pwm_out,
   output logic              wrap,
   output logic              irq,
   output logic [WIDTH-1:0]  duty_active,
   output logic [PCNT_W-1:0] period_cnt
);

`ifdef PWM_POL_INV_EN
   localparam logic PWM_IDLE = 1'b1;
`else
   localparam logic PWM_IDLE = 1'b0;
`endif

   logic [WIDTH-1:0] count_q;
   logic             prev_valid;
   logic [WIDTH-1:0] shadow;
   logic             pending;

   logic             wrap_det;
   logic [WIDTH-1:0] duty_eff;
   logic             pending_next;
   logic             irq_next;
   logic             cmp;
   logic             pwm_next;

   // A count that drops below last cycle's sample is a period boundary (rollover or downward load).
   always_comb begin
      wrap_det = prev_valid && (count < count_q);
   end

   // A write coinciding with a wrap bypasses the shadow so the new duty governs this very period.
   always_comb begin
      duty_eff     = duty_active;
      pending_next = pending;
      if (wrap_det) begin
         pending_next = 1'b0;
         if (duty_wr) begin
            duty_eff = duty_in;
         end else if (pending) begin
            duty_eff = shadow;
         end
      end else if (duty_wr) begin
         pending_next = 1'b1;
      end
   end

   always_comb begin
      irq_next = irq;
      if (wrap_det) begin
         irq_next = 1'b1;
      end else if (irq_clr) begin
         irq_next = 1'b0;
      end
   end

   always_comb begin
      cmp = (count < duty_eff);
`ifdef PWM_POL_INV_EN
      pwm_next = ~cmp;
`else
      pwm_next = cmp;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q     <= '0;
         prev_valid  <= 1'b0;
         shadow      <= '0;
         pending     <= 1'b0;
         duty_active <= '0;
         pwm_out     <= PWM_IDLE;
         wrap        <= 1'b0;
         irq         <= 1'b0;
         period_cnt  <= '0;
      end else begin
         count_q     <= count;
         prev_valid  <= 1'b1;
         pending     <= pending_next;
         duty_active <= duty_eff;
         pwm_out     <= pwm_next;
         wrap        <= wrap_det;
         irq         <= irq_next;
         if (duty_wr) begin
            shadow <= duty_in;
         end
         if (wrap_det) begin
            period_cnt <= period_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pwm_from_count.sv
// Self-checking bench for pwm_from_count: fixed vector table, full-period duty sequences,
// and randomized stimulus against a behavioural model.
module tb_pwm_from_count;

`ifdef PWM_POL_INV_EN
   localparam logic INV = 1'b1;
`else
   localparam logic INV = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  count;
   logic        duty_wr;
   logic [7:0]  duty_in;
   logic        irq_clr;
   logic        pwm_out;
   logic        wrap;
   logic        irq;
   logic [7:0]  duty_active;
   logic [15:0] period_cnt;

   int numCompared = 0;
   int numMismatched = 0;

   pwm_from_count #(.WIDTH(8), .PCNT_W(16)) dut (
      .clk(clk),
      .rst(rst),
      .count(count),
      .duty_wr(duty_wr),
      .duty_in(duty_in),
      .irq_clr(irq_clr),
      .pwm_out(pwm_out),
      .wrap(wrap),
      .irq(irq),
      .duty_active(duty_active),
      .period_cnt(period_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural model: writes since the last boundary are queued; a boundary adopts the newest.
   bit         mHavePrev;
   int         mPrev;
   int         mWrites[$];
   int         mDuty;
   bit         mHigh;
   bit         mWrap;
   bit         mIrq;
   int         mPeriods;

   task automatic modelStep(input bit r, input int c, input bit wr, input int din, input bit clr);
      bit boundary;
      if (r) begin
         mHavePrev = 0; mPrev = 0; mWrites.delete();
         mDuty = 0; mHigh = 0; mWrap = 0; mIrq = 0; mPeriods = 0;
      end else begin
         boundary = mHavePrev && (c < mPrev);
         if (boundary) begin
            if (wr) mDuty = din;
            else if (mWrites.size() > 0) mDuty = mWrites[$];
            mWrites.delete();
            mPeriods = (mPeriods + 1) % 65536;
            mIrq = 1;
         end else begin
            if (wr) mWrites.push_back(din);
            if (clr) mIrq = 0;
         end
         mHigh = (c < mDuty);
         mWrap = boundary;
         mPrev = c;
         mHavePrev = 1;
      end
   endtask

   task automatic applyStimulus(input bit r, input logic [7:0] c, input bit wr,
                                input logic [7:0] din, input bit clr);
      rst = r; count = c; duty_wr = wr; duty_in = din; irq_clr = clr;
      @(posedge clk);
      modelStep(r, int'(c), wr, int'(din), clr);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic ePwmHigh, input logic eWrap,
                              input logic eIrq, input logic [7:0] eDuty, input logic [15:0] ePcnt);
      logic ePwm;
      ePwm = ePwmHigh ^ INV;
      numCompared += 5;
      if (pwm_out !== ePwm) begin
         numMismatched++;
         $display("[TB] FAIL %s pwm_out: got %b expected %b", tag, pwm_out, ePwm);
      end
      if (wrap !== eWrap) begin
         numMismatched++;
         $display("[TB] FAIL %s wrap: got %b expected %b", tag, wrap, eWrap);
      end
      if (irq !== eIrq) begin
         numMismatched++;
         $display("[TB] FAIL %s irq: got %b expected %b", tag, irq, eIrq);
      end
      if (duty_active !== eDuty) begin
         numMismatched++;
         $display("[TB] FAIL %s duty_active: got %0d expected %0d", tag, duty_active, eDuty);
      end
      if (period_cnt !== ePcnt) begin
         numMismatched++;
         $display("[TB] FAIL %s period_cnt: got %0d expected %0d", tag, period_cnt, ePcnt);
      end
   endtask

   task automatic checkModel(input string tag);
      checkOutput(tag, mHigh, mWrap, mIrq, mDuty[7:0], mPeriods[15:0]);
   endtask

   typedef struct {
      logic       r;
      logic [7:0] c;
      logic       wr;
      logic [7:0] din;
      logic       clr;
      logic       ePwm;
      logic       eWrap;
      logic       eIrq;
      logic [7:0] eDuty;
      logic [15:0] ePcnt;
   } vec_t;

   vec_t vecs[23];

   initial begin
      int highHits;
      logic [7:0] cur;
      int sel;
      bit r;
      bit wr;
      bit clr;
      logic [7:0] din;
      logic [7:0] nextCount;

      //             r  cnt  wr din  clr  pwm wrp irq duty pcnt
      vecs[0]  = '{1, 0,   0, 0,   0,   0,  0,  0,  0,   0};
      vecs[1]  = '{0, 0,   0, 0,   0,   0,  0,  0,  0,   0};
      vecs[2]  = '{0, 0,   0, 0,   0,   0,  0,  0,  0,   0};
      vecs[3]  = '{0, 0,   0, 0,   0,   0,  0,  0,  0,   0};
      vecs[4]  = '{0, 0,   0, 0,   0,   0,  0,  0,  0,   0};
      vecs[5]  = '{0, 0,   0, 0,   0,   0,  0,  0,  0,   0};
      vecs[6]  = '{0, 50,  1, 100, 0,   0,  0,  0,  0,   0};
      vecs[7]  = '{0, 10,  0, 0,   0,   1,  1,  1,  100, 1};
      vecs[8]  = '{0, 11,  0, 0,   1,   1,  0,  0,  100, 1};
      vecs[9]  = '{0, 200, 0, 0,   0,   0,  0,  0,  100, 1};
      vecs[10] = '{0, 50,  0, 0,   0,   1,  1,  1,  100, 2};
      vecs[11] = '{0, 50,  0, 0,   1,   1,  0,  0,  100, 2};
      vecs[12] = '{0, 5,   1, 200, 1,   1,  1,  1,  200, 3};
      vecs[13] = '{0, 199, 0, 0,   0,   1,  0,  1,  200, 3};
      vecs[14] = '{0, 200, 0, 0,   0,   0,  0,  1,  200, 3};
      vecs[15] = '{0, 100, 1, 30,  0,   0,  1,  1,  30,  4};
      vecs[16] = '{0, 120, 1, 40,  0,   0,  0,  1,  30,  4};
      vecs[17] = '{0, 130, 1, 60,  0,   0,  0,  1,  30,  4};
      vecs[18] = '{0, 0,   0, 0,   0,   1,  1,  1,  60,  5};
      vecs[19] = '{0, 20,  1, 7,   0,   1,  0,  1,  60,  5};
      vecs[20] = '{1, 20,  0, 0,   0,   0,  0,  0,  0,   0};
      vecs[21] = '{0, 5,   0, 0,   0,   0,  0,  0,  0,   0};
      vecs[22] = '{0, 3,   0, 0,   0,   0,  1,  1,  0,   1};

      rst = 1'b1; count = '0; duty_wr = 1'b0; duty_in = '0; irq_clr = 1'b0;
      #2;

      for (int i = 0; i < 23; i++) begin
         applyStimulus(vecs[i].r, vecs[i].c, vecs[i].wr, vecs[i].din, vecs[i].clr);
         checkOutput($sformatf("vec%0d", i), vecs[i].ePwm, vecs[i].eWrap, vecs[i].eIrq,
                     vecs[i].eDuty, vecs[i].ePcnt);
      end

      // Write 100 at count 10, run to 255: nothing applies until the rollover.
      applyStimulus(1, 0, 0, 0, 0);
      checkModel("seqReset");
      applyStimulus(0, 10, 1, 100, 0);
      for (int c = 11; c <= 255; c++) applyStimulus(0, c[7:0], 0, 0, 0);
      checkOutput("prewrap", 0, 0, 0, 0, 0);

      // Full period at duty 100: counts 0..99 high.
      highHits = 0;
      for (int c = 0; c <= 255; c++) begin
         applyStimulus(0, c[7:0], 0, 0, 0);
         if (c == 0) checkOutput("firstWrap", 1, 1, 1, 100, 1);
         else checkModel($sformatf("duty100_c%0d", c));
         if ((pwm_out ^ INV) === 1'b1) highHits++;
      end
      numCompared++;
      if (highHits != 100) begin
         numMismatched++;
         $display("[TB] FAIL highCount100: got %0d expected 100", highHits);
      end

      // Write 200 exactly on the rollover cycle, with irq_clr also asserted.
      highHits = 0;
      for (int c = 0; c <= 255; c++) begin
         applyStimulus(0, c[7:0], c == 0, 200, c == 0);
         if (c == 0) checkOutput("bypassWrap", 1, 1, 1, 200, 2);
         else checkModel($sformatf("duty200_c%0d", c));
         if ((pwm_out ^ INV) === 1'b1) highHits++;
      end
      numCompared++;
      if (highHits != 200) begin
         numMismatched++;
         $display("[TB] FAIL highCount200: got %0d expected 200", highHits);
      end
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 1);
      checkOutput("irqClearLater", 1, 0, 0, 200, 3);

      // Duty 255 is low only at count 255.
      applyStimulus(0, 2, 1, 255, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("duty255_c0", 1, 1, 1, 255, 4);
      applyStimulus(0, 254, 0, 0, 0);
      checkOutput("duty255_c254", 1, 0, 1, 255, 4);
      applyStimulus(0, 255, 0, 0, 0);
      checkOutput("duty255_c255", 0, 0, 1, 255, 4);

      // Randomized run against the model.
      applyStimulus(1, 0, 0, 0, 0);
      checkModel("rndReset");
      cur = 8'd0;
      for (int n = 0; n < 4000; n++) begin
         sel = $urandom_range(0, 99);
         r = (sel < 2);
         if (sel < 8) nextCount = 8'($urandom);
         else if (sel < 12) nextCount = cur;
         else nextCount = cur + 8'd1;
         cur = nextCount;
         wr = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 5))
            0: din = 8'd0;
            1: din = 8'd255;
            default: din = 8'($urandom);
         endcase
         clr = ($urandom_range(0, 7) == 0);
         applyStimulus(r, cur, wr, din, clr);
         checkModel($sformatf("rnd%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule

// File: doc/pwm_from_count.md
Name: pwm_from_count

Overview:
- Downstream consumer of the 8-bit up_counter `count` bus; converts the free-running or loaded count into a PWM waveform.
- Duty is programmable and double-buffered; a new duty value takes effect only at a period boundary, defined as a count wrap.
- Also flags each period boundary with a sticky interrupt and a period counter, for software or sequencer use.

Parameters:
- WIDTH, 8, width of count and duty buses; must match the upstream counter.
- PCNT_W, 16, width of the period (wrap) counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- count  input  WIDTH  count value from the upstream up_counter, sampled every cycle.
- duty_wr  input  1  single-cycle strobe; writes duty_in into the shadow register.
- duty_in  input  WIDTH  new duty value (high-time in counts).
- irq_clr  input  1  clears the sticky irq.
- pwm_out  output  1  registered PWM output.
- wrap  output  1  registered one-cycle pulse marking a detected period boundary.
- irq  output  1  sticky period-boundary flag.
- duty_active  output  WIDTH  duty value currently used for the compare.
- period_cnt  output  PCNT_W  number of wraps since reset; rolls over at 2^PCNT_W.

Behaviour:
- Reset (rst=1 at a clock edge) clears every register to 0:
  - pwm_out=0, wrap=0, irq=0, duty_active=0, period_cnt=0;
  - shadow duty=0, pending=0, count_q=0, prev_valid=0.
- Sampling:
  - count_q <= count every cycle.
  - prev_valid <= 1 on the first cycle after reset.
- Wrap detection (combinational, internal): wrap_det = prev_valid && (count < count_q).
  - Covers 255->0 rollover and a load to a lower value.
  - count == count_q (stalled) is not a wrap.
  - A load to a higher value is not a wrap.
  - First cycle after reset: wrap_det is never asserted.
- Shadow duty:
  - duty_wr=1: shadow <= duty_in, pending <= 1.
  - A later duty_wr before a wrap overwrites the shadow (last write wins).
- Duty apply, on wrap_det:
  - If pending: duty_active <= shadow, pending <= 0.
  - If duty_wr and wrap_det occur in the same cycle, duty_in bypasses to duty_active, and pending is left 0.
- Compare:
  - duty_eff = value duty_active takes this cycle (post-apply).
  - pwm_out <= (count < duty_eff). Latency: 1 cycle from count to pwm_out.
  - duty 0 gives pwm_out constantly 0.
  - duty 255 gives pwm_out low only when count=255.
- wrap <= wrap_det, a one-cycle pulse registered with pwm_out.
- period_cnt <= period_cnt + 1 on wrap_det; rolls over at 2^PCNT_W, no saturation.
- irq:
  - Set on wrap_det; cleared by irq_clr.
  - If irq_clr and wrap_det occur in the same cycle, set wins (irq=1).
- Reset mid-period:
  - Aborts the period and discards the pending shadow.
  - The next wrap is detected only after prev_valid re-arms.
- No FSM beyond the prev_valid arm flag and the pending bit; all outputs are registered.

Optional Feature:
- Macro: PWM_POL_INV_EN.
- Defined:
  - pwm_out <= ~(count < duty_eff) during normal operation, giving an active-low waveform.
  - Reset value of pwm_out is 1, so the output is idle-inactive.
- Undefined: active-high output as described above, with reset value 0.
- wrap, irq, period_cnt and duty_active are unaffected in both cases.

Test Plan:
- Reset, then count held at 0 for 5 cycles:
  - all outputs stay 0;
  - no wrap fires on the first sample.
- duty_wr with duty_in=100 while count runs 10..255, then 0:
  - duty_active remains 0 and pwm_out stays 0 until the wrap;
  - wrap pulses 1 cycle after count=0 is presented;
  - duty_active=100; period_cnt=1; irq=1.
- duty_active=100, free-running count:
  - pwm_out is high for counts 0..99 and low for 100..255, each delayed by 1 cycle;
  - that is 100 high cycles per 256-cycle period.
- duty_wr=1 with duty_in=200 in the same cycle count goes 255->0:
  - duty_active=200 immediately, with no pending left over;
  - the next period shows 200 high cycles.
- irq_clr asserted in the cycle of a wrap: irq stays 1; irq_clr asserted in a later, non-wrap cycle: irq=0.
- Upstream load 8'd10 while count=50:
  - wrap detected; period_cnt increments.
- Upstream load 8'd200 while count=50:
  - no wrap; period_cnt unchanged.
